wb_write_arbiter: RTL and testbench

- Writer-side counterpart of the register file. It owns the single regfile write port and arbitrates between two sources:
  - the in-order pipeline writeback (ALU/MEM results);
  - out-of-order load returns from the AXI-Lite load unit.
- Load returns are buffered in a small FIFO.
- A 32-entry pending-load scoreboard drives the ID-stage stall for RAW and WAW hazards on registers still awaiting load data.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_write_arbiter_if.sv | 51 +++++
 rtl/wb_load_fifo.sv | 53 +++++
 rtl/wb_write_arbiter.sv | 105 ++++++++++
 tb/tb_wb_write_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared sizing defaults and the load-return record for the writeback arbiter.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;
    localparam int LQ_DEPTH   = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } ld_ret_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of pipeline writeback, load issue/return, ID hazard query and regfile write signals.
interface wb_write_arbiter_if #(
    parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W,
    parameter int REG_DATA_W = wb_pkg::REG_DATA_W
) ();
    import wb_pkg::*;

    logic                  pipe_wb_en_i;
    logic [REG_ADDR_W-1:0] pipe_wb_addr_i;
    logic [REG_DATA_W-1:0] pipe_wb_data_i;
    logic                  ld_issue_i;
    logic [REG_ADDR_W-1:0] ld_issue_addr_i;
    logic                  ld_ret_valid_i;
    logic [REG_ADDR_W-1:0] ld_ret_addr_i;
    logic [REG_DATA_W-1:0] ld_ret_data_i;
    logic                  ld_ret_ready_o;
    logic                  id_rd_en_1_i;
    logic                  id_rd_en_2_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_1_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_2_i;
    logic                  id_dest_en_i;
    logic [REG_ADDR_W-1:0] id_dest_addr_i;
    logic                  stall_o;
    logic                  write_en_o;
    logic [REG_ADDR_W-1:0] write_addr_o;
    logic [REG_DATA_W-1:0] write_data_o;

    // The arbiter is the slave; the pipeline/load unit/ID environment is the master.
    modport slave (
        input  pipe_wb_en_i, pipe_wb_addr_i, pipe_wb_data_i,
        input  ld_issue_i, ld_issue_addr_i,
        input  ld_ret_valid_i, ld_ret_addr_i, ld_ret_data_i,
        output ld_ret_ready_o,
        input  id_rd_en_1_i, id_rd_en_2_i, id_rd_addr_1_i, id_rd_addr_2_i,
        input  id_dest_en_i, id_dest_addr_i,
        output stall_o,
        output write_en_o, write_addr_o, write_data_o
    );

    modport master (
        output pipe_wb_en_i, pipe_wb_addr_i, pipe_wb_data_i,
        output ld_issue_i, ld_issue_addr_i,
        output ld_ret_valid_i, ld_ret_addr_i, ld_ret_data_i,
        input  ld_ret_ready_o,
        output id_rd_en_1_i, id_rd_en_2_i, id_rd_addr_1_i, id_rd_addr_2_i,
        output id_dest_en_i, id_dest_addr_i,
        input  stall_o,
        input  write_en_o, write_addr_o, write_data_o
    );

endinterface

// File: rtl/wb_load_fifo.sv
// Generic synchronous FIFO (power-of-two depth) with push/pop, full/empty and occupancy count.
module wb_load_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 37,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    import wb_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Regfile write-port owner: pipeline writeback vs. buffered load returns, plus pending-load scoreboard.
// Optional same-cycle load-return bypass when WB_LQ_BYPASS_EN is defined.
module wb_write_arbiter #(
    parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W,
    parameter int REG_DATA_W = wb_pkg::REG_DATA_W,
    parameter int REG_NUM    = wb_pkg::REG_NUM,
    parameter int LQ_DEPTH   = wb_pkg::LQ_DEPTH
) (
    input logic              clk,
    input logic              rst,
    wb_write_arbiter_if.slave bus
);
    import wb_pkg::*;

    localparam int ENTRY_W = REG_ADDR_W + REG_DATA_W;
    localparam int CNT_W   = $clog2(LQ_DEPTH + 1);

    logic [REG_NUM-1:0]    pending;
    logic [REG_NUM-1:0]    pending_next;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    head_entry;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [REG_DATA_W-1:0] head_data;
    logic                  ret_ready;
    logic                  ret_accept;
    logic                  ret_push;
    logic                  bypass;
    logic                  drain;

    assign {head_addr, head_data} = head_entry;

    // Ready uses the pre-edge count, so a full queue refuses a return even while draining.
    assign ret_ready  = rst && (fifo_count < CNT_W'(LQ_DEPTH));
    assign ret_accept = bus.ld_ret_valid_i && ret_ready;
    assign drain      = rst && !bus.pipe_wb_en_i && !fifo_empty;

`ifdef WB_LQ_BYPASS_EN
    assign bypass = ret_accept && fifo_empty && !bus.pipe_wb_en_i && (bus.ld_ret_addr_i != '0);
`else
    assign bypass = 1'b0;
`endif

    // Returns to r0 are swallowed: accepted on the bus but never queued.
    assign ret_push = ret_accept && !fifo_full && (bus.ld_ret_addr_i != '0) && !bypass;

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_load_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_push),
        .pop   (drain),
        .wdata ({bus.ld_ret_addr_i, bus.ld_ret_data_i}),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pipeline writeback always wins; the queue only gets the port when the pipe is idle.
    always_comb begin
        bus.write_en_o   = 1'b0;
        bus.write_addr_o = '0;
        bus.write_data_o = '0;
        if (rst) begin
            if (bus.pipe_wb_en_i) begin
                bus.write_en_o   = 1'b1;
                bus.write_addr_o = bus.pipe_wb_addr_i;
                bus.write_data_o = bus.pipe_wb_data_i;
            end else if (!fifo_empty) begin
                bus.write_en_o   = 1'b1;
                bus.write_addr_o = head_addr;
                bus.write_data_o = head_data;
            end else if (bypass) begin
                bus.write_en_o   = 1'b1;
                bus.write_addr_o = bus.ld_ret_addr_i;
                bus.write_data_o = bus.ld_ret_data_i;
            end
        end
    end

    // A new issue to the same register outranks the clear from an older return's write.
    always_comb begin
        pending_next = pending;
        if (drain)  pending_next[head_addr] = 1'b0;
        if (bypass) pending_next[bus.ld_ret_addr_i] = 1'b0;
        if (bus.ld_issue_i && (bus.ld_issue_addr_i != '0))
            pending_next[bus.ld_issue_addr_i] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) pending <= '0;
        else      pending <= pending_next;
    end

    assign bus.ld_ret_ready_o = ret_ready;
    assign bus.stall_o = rst && ((bus.id_rd_en_1_i && pending[bus.id_rd_addr_1_i]) ||
                                 (bus.id_rd_en_2_i && pending[bus.id_rd_addr_2_i]) ||
                                 (bus.id_dest_en_i && pending[bus.id_dest_addr_i]));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed plus randomized bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    ld_ret_t     lq[$];
    bit          pend [REG_NUM];
    int unsigned outstanding[$];
    bit          last_accept;

    always #5 clk = ~clk;

    wb_write_arbiter_if bus ();

    wb_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        bus.pipe_wb_en_i    = 1'b0;
        bus.pipe_wb_addr_i  = '0;
        bus.pipe_wb_data_i  = '0;
        bus.ld_issue_i      = 1'b0;
        bus.ld_issue_addr_i = '0;
        bus.ld_ret_valid_i  = 1'b0;
        bus.ld_ret_addr_i   = '0;
        bus.ld_ret_data_i   = '0;
        bus.id_rd_en_1_i    = 1'b0;
        bus.id_rd_en_2_i    = 1'b0;
        bus.id_rd_addr_1_i  = '0;
        bus.id_rd_addr_2_i  = '0;
        bus.id_dest_en_i    = 1'b0;
        bus.id_dest_addr_i  = '0;
    endtask

    function automatic bit model_bypass();
`ifdef WB_LQ_BYPASS_EN
        return rst && !bus.pipe_wb_en_i && (lq.size() == 0) &&
               bus.ld_ret_valid_i && (bus.ld_ret_addr_i != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_busy(input int unsigned a);
        if (pend[a]) return 1'b1;
        foreach (outstanding[i]) if (outstanding[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput();
        bit          exp_ready;
        bit          exp_stall;
        bit          exp_en;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        exp_ready = rst && (lq.size() < LQ_DEPTH);
        exp_en    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        if (rst) begin
            if (bus.pipe_wb_en_i) begin
                exp_en = 1'b1; exp_addr = 32'(bus.pipe_wb_addr_i); exp_data = bus.pipe_wb_data_i;
            end else if (lq.size() > 0) begin
                exp_en = 1'b1; exp_addr = 32'(lq[0].addr); exp_data = lq[0].data;
            end else if (model_bypass()) begin
                exp_en = 1'b1; exp_addr = 32'(bus.ld_ret_addr_i); exp_data = bus.ld_ret_data_i;
            end
        end
        exp_stall = rst && ((bus.id_rd_en_1_i && pend[bus.id_rd_addr_1_i]) ||
                            (bus.id_rd_en_2_i && pend[bus.id_rd_addr_2_i]) ||
                            (bus.id_dest_en_i && pend[bus.id_dest_addr_i]));
        check("ld_ret_ready", 32'(bus.ld_ret_ready_o), 32'(exp_ready));
        check("stall", 32'(bus.stall_o), 32'(exp_stall));
        check("write_en", 32'(bus.write_en_o), 32'(exp_en));
        check("write_addr", 32'(bus.write_addr_o), exp_addr);
        check("write_data", bus.write_data_o, exp_data);
    endtask

    // Commit one clock edge worth of behaviour into the model, using the inputs still on the bus.
    task automatic updateModel();
        bit      accept;
        bit      byp;
        ld_ret_t h;
        last_accept = 1'b0;
        if (!rst) begin
            lq.delete();
            foreach (pend[i]) pend[i] = 1'b0;
            return;
        end
        byp    = model_bypass();
        accept = bus.ld_ret_valid_i && (lq.size() < LQ_DEPTH);
        last_accept = accept;
        if (!bus.pipe_wb_en_i && lq.size() > 0) begin
            h = lq.pop_front();
            check("drain_target_pending", 32'(pend[h.addr]), 32'd1);
            pend[h.addr] = 1'b0;
        end
        if (byp) begin
            check("bypass_target_pending", 32'(pend[bus.ld_ret_addr_i]), 32'd1);
            pend[bus.ld_ret_addr_i] = 1'b0;
        end
        if (accept && bus.ld_ret_addr_i != 0 && !byp) begin
            h.addr = bus.ld_ret_addr_i;
            h.data = bus.ld_ret_data_i;
            lq.push_back(h);
        end
        if (bus.ld_issue_i && bus.ld_issue_addr_i != 0) pend[bus.ld_issue_addr_i] = 1'b1;
    endtask

    task automatic applyStimulus();
        #4;
        checkOutput();
    endtask

    task automatic advance();
        updateModel();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          ret_idx;
        int unsigned a;
        bit          did_issue;

        clearInputs();
        foreach (pend[i]) pend[i] = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a return and a pipe write pending on the bus.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clearInputs();
            bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd7; bus.ld_ret_data_i = 32'h0BAD0BAD;
            bus.pipe_wb_en_i = 1'b1; bus.pipe_wb_addr_i = 5'd2; bus.pipe_wb_data_i = 32'h22;
            bus.id_rd_en_1_i = 1'b1; bus.id_rd_addr_1_i = 5'd7;
            applyStimulus();
            check("reset_write_en", 32'(bus.write_en_o), 32'd0);
            check("reset_ready", 32'(bus.ld_ret_ready_o), 32'd0);
            check("reset_stall", 32'(bus.stall_o), 32'd0);
            advance();
        end
        rst = 1'b1;
        clearInputs();
        applyStimulus();
        check("ready_after_reset", 32'(bus.ld_ret_ready_o), 32'd1);
        advance();

        // Load to r5, dependent read stalls, return drains to the regfile.
        clearInputs(); bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'd5;
        applyStimulus(); advance();
        clearInputs(); bus.id_rd_en_1_i = 1'b1; bus.id_rd_addr_1_i = 5'd5;
        bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd5; bus.ld_ret_data_i = 32'hDEADBEEF;
        applyStimulus();
        check("r5_stall", 32'(bus.stall_o), 32'd1);
`ifdef WB_LQ_BYPASS_EN
        check("r5_bypass_en", 32'(bus.write_en_o), 32'd1);
        check("r5_bypass_data", bus.write_data_o, 32'hDEADBEEF);
`else
        check("r5_no_early_write", 32'(bus.write_en_o), 32'd0);
`endif
        advance();
        clearInputs(); bus.id_rd_en_1_i = 1'b1; bus.id_rd_addr_1_i = 5'd5;
        applyStimulus();
`ifndef WB_LQ_BYPASS_EN
        check("r5_drain_en", 32'(bus.write_en_o), 32'd1);
        check("r5_drain_addr", 32'(bus.write_addr_o), 32'd5);
        check("r5_drain_data", bus.write_data_o, 32'hDEADBEEF);
        check("r5_stall_extra", 32'(bus.stall_o), 32'd1);
        advance();
        clearInputs(); bus.id_rd_en_1_i = 1'b1; bus.id_rd_addr_1_i = 5'd5;
        applyStimulus();
`endif
        check("r5_stall_released", 32'(bus.stall_o), 32'd0);
        advance();

        // Pipe holds the port for 4 cycles; two returns fill the queue, then drain in order.
        clearInputs(); bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'd6;
        applyStimulus(); advance();
        clearInputs(); bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'd7;
        applyStimulus(); advance();
        for (int i = 0; i < 4; i++) begin
            clearInputs();
            bus.pipe_wb_en_i = 1'b1; bus.pipe_wb_addr_i = 5'd3; bus.pipe_wb_data_i = 32'h11;
            if (i == 0) begin bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd6; bus.ld_ret_data_i = 32'h66; end
            if (i == 1) begin bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd7; bus.ld_ret_data_i = 32'h77; end
            applyStimulus();
            check("pipe_priority_addr", 32'(bus.write_addr_o), 32'd3);
            check("fill_ready", 32'(bus.ld_ret_ready_o), (i < 2) ? 32'd1 : 32'd0);
            advance();
        end
        clearInputs();
        applyStimulus();
        check("drain_first_addr", 32'(bus.write_addr_o), 32'd6);
        check("drain_first_data", bus.write_data_o, 32'h66);
        check("full_drain_ready", 32'(bus.ld_ret_ready_o), 32'd0);
        advance();
        clearInputs();
        applyStimulus();
        check("drain_second_addr", 32'(bus.write_addr_o), 32'd7);
        check("drain_second_data", bus.write_data_o, 32'h77);
        advance();

        // Re-issue to r9 in the same cycle an older r9 return drains: set wins.
        clearInputs(); bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'd9;
        applyStimulus(); advance();
        clearInputs(); bus.pipe_wb_en_i = 1'b1; bus.pipe_wb_addr_i = 5'd1; bus.pipe_wb_data_i = 32'h1;
        bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd9; bus.ld_ret_data_i = 32'h99;
        applyStimulus(); advance();
        clearInputs(); bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'd9;
        applyStimulus();
        check("r9_drain_addr", 32'(bus.write_addr_o), 32'd9);
        advance();
        clearInputs(); bus.id_rd_en_2_i = 1'b1; bus.id_rd_addr_2_i = 5'd9;
        applyStimulus();
        check("r9_still_pending", 32'(bus.stall_o), 32'd1);
        advance();
        clearInputs(); bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd9; bus.ld_ret_data_i = 32'h9999;
        applyStimulus(); advance();
        for (int i = 0; i < 2; i++) begin
            clearInputs(); bus.id_dest_en_i = 1'b1; bus.id_dest_addr_i = 5'd9;
            applyStimulus(); advance();
        end

        // r0 issue and return leave no trace.
        clearInputs(); bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'd0;
        bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd0; bus.ld_ret_data_i = 32'h1234;
        applyStimulus();
        check("r0_no_write", 32'(bus.write_en_o), 32'd0);
        advance();
        clearInputs(); bus.id_rd_en_1_i = 1'b1; bus.id_rd_addr_1_i = 5'd0;
        applyStimulus();
        check("r0_no_write_late", 32'(bus.write_en_o), 32'd0);
        check("r0_ready", 32'(bus.ld_ret_ready_o), 32'd1);
        check("r0_no_stall", 32'(bus.stall_o), 32'd0);
        advance();

        // Return to r4 with empty queue and idle pipe: bypass timing if enabled.
        clearInputs(); bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'd4;
        applyStimulus(); advance();
        clearInputs(); bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd4; bus.ld_ret_data_i = 32'hCAFE0000;
        applyStimulus();
`ifdef WB_LQ_BYPASS_EN
        check("r4_same_cycle", 32'(bus.write_en_o), 32'd1);
`else
        check("r4_same_cycle", 32'(bus.write_en_o), 32'd0);
`endif
        advance();
        clearInputs();
        applyStimulus();
`ifdef WB_LQ_BYPASS_EN
        check("r4_next_cycle", 32'(bus.write_en_o), 32'd0);
`else
        check("r4_next_cycle", 32'(bus.write_en_o), 32'd1);
        check("r4_next_data", bus.write_data_o, 32'hCAFE0000);
`endif
        advance();

        // Randomized traffic with a mid-run reset.
        for (int cyc = 0; cyc < 400; cyc++) begin
            clearInputs();
            rst = !(cyc >= 200 && cyc < 202);
            did_issue = 1'b0;
            ret_idx = -1;
            if ($urandom_range(0, 9) < 4) begin
                bus.pipe_wb_en_i   = 1'b1;
                bus.pipe_wb_addr_i = 5'($urandom_range(1, REG_NUM - 1));
                bus.pipe_wb_data_i = $urandom();
            end
            a = $urandom_range(0, REG_NUM - 1);
            if ($urandom_range(0, 9) < 3 && (a == 0 || !is_busy(a))) begin
                bus.ld_issue_i = 1'b1; bus.ld_issue_addr_i = 5'(a);
                did_issue = (a != 0);
            end
            if (outstanding.size() > 0 && $urandom_range(0, 9) < 5) begin
                ret_idx = int'($urandom_range(0, outstanding.size() - 1));
                bus.ld_ret_valid_i = 1'b1;
                bus.ld_ret_addr_i  = 5'(outstanding[ret_idx]);
                bus.ld_ret_data_i  = $urandom();
            end else if ($urandom_range(0, 19) == 0) begin
                bus.ld_ret_valid_i = 1'b1; bus.ld_ret_addr_i = 5'd0; bus.ld_ret_data_i = $urandom();
            end
            bus.id_rd_en_1_i = 1'($urandom_range(0, 1)); bus.id_rd_addr_1_i = 5'($urandom_range(0, REG_NUM - 1));
            bus.id_rd_en_2_i = 1'($urandom_range(0, 1)); bus.id_rd_addr_2_i = 5'($urandom_range(0, REG_NUM - 1));
            bus.id_dest_en_i = 1'($urandom_range(0, 1)); bus.id_dest_addr_i = 5'($urandom_range(0, REG_NUM - 1));
            applyStimulus();
            advance();
            if (!rst) begin
                outstanding.delete();
            end else begin
                if (ret_idx >= 0 && last_accept) outstanding.delete(ret_idx);
                if (did_issue) outstanding.push_back(a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
